// File: rtl/matrix_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_result_streamer_if
// Brief    : Matrix-capture and element-stream handshake bundle.
// Revision : 1.0
// ============================================================================
interface matrix_result_streamer_if #(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int ELEM_W = 10
);
    localparam int MAT_W = ROWS * COLS * ELEM_W;

    logic              in_valid;
    logic              in_ready;
    logic [MAT_W-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic [3:0]        out_row;
    logic [3:0]        out_col;
    logic              out_last;
    logic              busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/matrix_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_result_streamer
// Brief    : Captures a packed ROWSxCOLS matrix and streams it row-major.
// Revision : 1.0
// ============================================================================
module matrix_result_streamer #(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int ELEM_W = 10
) (
    input  wire logic               clk,
    input  wire logic               rst,
    matrix_result_streamer_if.slave bus
);
    localparam int         MAT_W      = ROWS * COLS * ELEM_W;
    localparam logic [3:0] c_last_row = 4'(ROWS - 1);
    localparam logic [3:0] c_last_col = 4'(COLS - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_en;
    logic [MAT_W-1:0] r_shift;
    logic [3:0]       r_row;
    logic [3:0]       r_col;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_at_last;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_at_last  = (r_row == c_last_row) && (r_col == c_last_col);
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = w_out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready depends on state and the post-reset enable only, never on out_ready
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = r_in_en;
                if (bus.in_valid && r_in_en) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                w_out_valid = 1'b1;
                if (bus.out_ready && w_at_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_en <= 1'b0;
            r_shift <= '0;
            r_row   <= 4'd0;
            r_col   <= 4'd0;
        end else begin
            r_in_en <= 1'b1;
            if (w_in_fire) begin
                r_shift <= bus.in_data;
                r_row   <= 4'd0;
                r_col   <= 4'd0;
            end else if (w_out_fire) begin
                // zero fill keeps out_data at 0 once the matrix is drained
                r_shift <= r_shift << ELEM_W;
                if (w_at_last) begin
                    r_row <= 4'd0;
                    r_col <= 4'd0;
                end else if (r_col == c_last_col) begin
                    r_col <= 4'd0;
                    r_row <= r_row + 4'd1;
                end else begin
                    r_col <= r_col + 4'd1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_shift[MAT_W-1 -: ELEM_W];
    assign bus.out_row   = r_row;
    assign bus.out_col   = r_col;
    assign bus.out_last  = w_out_valid && w_at_last;
    assign bus.busy      = (r_state == S_STREAM);

endmodule
`default_nettype wire
